// File: rtl/pipelined_barrel_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdpu_shift_pkg
// Description : Shared types and constant helpers for the pipelined barrel
//               shifter: shift-mode encoding and level-to-stage distribution.
// Revision    : 1.0 - initial release
// ============================================================================
package pdpu_shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_e;

    // Number of shift levels handled by one stage. Levels are spread as evenly
    // as possible; the earlier stages absorb the remainder.
    function automatic int levels_in_stage(int shift_width, int pipe_regs, int stage);
        if (pipe_regs <= 0) begin
            return shift_width;
        end
        return (shift_width / pipe_regs) + ((stage < (shift_width % pipe_regs)) ? 1 : 0);
    endfunction

    // Position (0 = MSB level) of the first level that belongs to a stage.
    function automatic int stage_first_level(int shift_width, int pipe_regs, int stage);
        int first;
        first = 0;
        for (int s = 0; s < stage; s++) begin
            first += levels_in_stage(shift_width, pipe_regs, s);
        end
        return first;
    endfunction

    // Stage that owns the level at a given position.
    function automatic int stage_of_level(int shift_width, int pipe_regs, int pos);
        int found;
        found = 0;
        for (int s = 0; s < pipe_regs; s++) begin
            if (pos >= stage_first_level(shift_width, pipe_regs, s)) begin
                found = s;
            end
        end
        return found;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_barrel_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter_if
// Description : Input/output valid-ready beat bundle of the barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_barrel_shifter_if
    import pdpu_shift_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int TAG_WIDTH   = 4
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [WIDTH-1:0]       operand_i;
    logic [SHIFT_WIDTH-1:0] shift_amount_i;
    shift_mode_e            mode_i;
    logic [TAG_WIDTH-1:0]   tag_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [WIDTH-1:0]       result_o;
    logic                   sticky_o;
    logic [TAG_WIDTH-1:0]   tag_o;

    // Shifter side
    modport slave (
        input  in_valid_i, operand_i, shift_amount_i, mode_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, sticky_o, tag_o
    );

    // Producer/consumer side
    modport master (
        output in_valid_i, operand_i, shift_amount_i, mode_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, sticky_o, tag_o
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_barrel_shifter_shift_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One combinational 2**k shift level for LSL/LSR/ASR/ROR with
//               extraction of the bits removed at this level.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import pdpu_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             enable,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] result,
    output logic             removed
);
    // Shifting by SHIFT >= WIDTH empties the masks' complements, so these
    // also cover the saturating levels without special cases.
    localparam logic [WIDTH-1:0] C_ONES      = '1;
    localparam logic [WIDTH-1:0] C_LOW_MASK  = ~(C_ONES << SHIFT);
    localparam logic [WIDTH-1:0] C_HIGH_MASK = ~(C_ONES >> SHIFT);
    // Rotation is modulo WIDTH; levels at or above WIDTH rotate by zero.
    localparam int               C_ROT       = SHIFT % WIDTH;

    // Apply this level's shift when its amount bit is set
    always_comb begin
        result  = operand;
        removed = 1'b0;
        if (enable) begin
            case (mode)
                SHIFT_LSL: begin
                    result  = operand << SHIFT;
                    removed = |(operand & C_HIGH_MASK);
                end
                SHIFT_LSR: begin
                    result  = operand >> SHIFT;
                    removed = |(operand & C_LOW_MASK);
                end
                SHIFT_ASR: begin
                    result  = $unsigned($signed(operand) >>> SHIFT);
                    removed = |(operand & C_LOW_MASK);
                end
                SHIFT_ROR: begin
                    result  = (operand >> C_ROT) | (operand << (WIDTH - C_ROT));
                    removed = 1'b0;
                end
                default: begin
                    result  = operand;
                    removed = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Multi-mode barrel shifter (LSL/LSR/ASR/ROR) with sticky bit,
//               amount saturation and an elastic valid/ready pipeline of
//               PIPE_REGS stages (0 = combinational pass-through).
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
    import pdpu_shift_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int PIPE_REGS   = 2,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    pipelined_barrel_shifter_if.slave   bus
);

    localparam int C_NREG = (PIPE_REGS > 0) ? PIPE_REGS : 1;

    // Everything that travels with a beat between levels and stages
    typedef struct packed {
        logic [WIDTH-1:0]       data;
        logic [SHIFT_WIDTH-1:0] amount;
        shift_mode_e            mode;
        logic                   sticky;
        logic [TAG_WIDTH-1:0]   tag;
    } payload_t;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
    end
    if ((2 ** SHIFT_WIDTH) < WIDTH) begin : g_bad_shift_width
        $error("pipelined_barrel_shifter: 2**SHIFT_WIDTH must be >= WIDTH");
    end
    if (PIPE_REGS < 0 || PIPE_REGS > SHIFT_WIDTH) begin : g_bad_pipe_regs
        $error("pipelined_barrel_shifter: PIPE_REGS must be in 0..SHIFT_WIDTH");
    end

    payload_t             w_entry;
    payload_t             w_lvl_in  [SHIFT_WIDTH];
    payload_t             w_lvl_out [SHIFT_WIDTH];
    payload_t             w_final;
    payload_t             r_stage   [C_NREG];
    logic [C_NREG-1:0]    r_valid;
    logic                 w_unused;

    assign w_entry = '{
        data:   bus.operand_i,
        amount: bus.shift_amount_i,
        mode:   bus.mode_i,
        sticky: 1'b0,
        tag:    bus.tag_i
    };

    // Level chain, MSB level first; a stage register sits in front of the
    // first level of every stage except stage 0.
    for (genvar p = 0; p < SHIFT_WIDTH; p++) begin : g_level
        localparam int C_BIT    = SHIFT_WIDTH - 1 - p;
        localparam int C_STAGE  = stage_of_level(SHIFT_WIDTH, PIPE_REGS, p);
        localparam bit C_REG_IN = (PIPE_REGS > 0) && (p > 0) &&
                                  (p == stage_first_level(SHIFT_WIDTH, PIPE_REGS, C_STAGE));
        localparam logic [SHIFT_WIDTH-1:0] C_CLEAR = ~(SHIFT_WIDTH'(1) << C_BIT);

        logic [WIDTH-1:0] w_data;
        logic             w_removed;

        if (p == 0) begin : g_from_input
            assign w_lvl_in[p] = w_entry;
        end else if (C_REG_IN) begin : g_from_reg
            assign w_lvl_in[p] = r_stage[C_STAGE-1];
        end else begin : g_from_prev
            assign w_lvl_in[p] = w_lvl_out[p-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .SHIFT (2 ** C_BIT)
        ) u_level (
            .operand (w_lvl_in[p].data),
            .enable  (w_lvl_in[p].amount[C_BIT]),
            .mode    (w_lvl_in[p].mode),
            .result  (w_data),
            .removed (w_removed)
        );

        // Consumed amount bits are cleared so only the remaining ones travel on
        assign w_lvl_out[p] = '{
            data:   w_data,
            amount: w_lvl_in[p].amount & C_CLEAR,
            mode:   w_lvl_in[p].mode,
            sticky: w_lvl_in[p].sticky | w_removed,
            tag:    w_lvl_in[p].tag
        };
    end

    if (PIPE_REGS == 0) begin : g_comb
        assign r_valid        = '0;
        assign r_stage[0]     = '0;
        assign w_final        = w_lvl_out[SHIFT_WIDTH-1];
        assign bus.out_valid_o = bus.in_valid_i;
        assign bus.in_ready_o  = bus.out_ready_i;
    end else begin : g_pipe
        payload_t               w_stage_d [PIPE_REGS];
        logic [PIPE_REGS-1:0]   w_up_valid;
        logic [PIPE_REGS-1:0]   w_load;

        for (genvar s = 0; s < PIPE_REGS; s++) begin : g_ctrl
            localparam int C_LAST = stage_first_level(SHIFT_WIDTH, PIPE_REGS, s) +
                                    levels_in_stage(SHIFT_WIDTH, PIPE_REGS, s) - 1;
            assign w_stage_d[s] = w_lvl_out[C_LAST];
            if (s == 0) begin : g_first
                assign w_up_valid[s] = bus.in_valid_i;
            end else begin : g_next
                assign w_up_valid[s] = r_valid[s-1];
            end
        end

        // A stage may load if it or any stage after it has a hole, or the
        // output is being drained this cycle.
        always_comb begin : p_load_chain
            logic w_gap;
            w_gap  = bus.out_ready_i;
            w_load = '0;
            for (int s = PIPE_REGS - 1; s >= 0; s--) begin
                w_gap     = w_gap | ~r_valid[s];
                w_load[s] = w_gap;
            end
        end

        // Stage registers: valid follows upstream, payload captured only for real beats
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid <= '0;
                for (int s = 0; s < PIPE_REGS; s++) begin
                    r_stage[s] <= '0;
                end
            end else begin
                for (int s = 0; s < PIPE_REGS; s++) begin
                    if (w_load[s]) begin
                        r_valid[s] <= w_up_valid[s];
                        if (w_up_valid[s]) begin
                            r_stage[s] <= w_stage_d[s];
                        end
                    end
                end
            end
        end

        assign w_final         = r_stage[PIPE_REGS-1];
        assign bus.out_valid_o = r_valid[PIPE_REGS-1];
        assign bus.in_ready_o  = w_load[0];
    end

    assign bus.result_o = w_final.data;
    assign bus.sticky_o = w_final.sticky;
    assign bus.tag_o    = w_final.tag;

    // Mode and the (fully consumed) amount are not needed past the last level
    assign w_unused = ^{w_final.amount, w_final.mode};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Self-checking bench: vector table, backpressure and reset
//               sequences, and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;
    import pdpu_shift_pkg::*;

    localparam int W  = 16;
    localparam int SW = 5;
    localparam int PR = 2;
    localparam int TW = 4;

    typedef struct {
        logic [15:0] op;
        logic [4:0]  amt;
        logic [1:0]  mode;
        logic [3:0]  tag;
        logic [15:0] res;
        logic        st;
    } vec_t;

    typedef struct {
        logic [15:0] op;
        logic [4:0]  amt;
        logic [1:0]  mode;
        logic [3:0]  tag;
    } beat_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   mon_in;
    int   mon_out;
    logic [20:0] sb [$];

    pipelined_barrel_shifter_if #(.WIDTH(W), .SHIFT_WIDTH(SW), .TAG_WIDTH(TW)) bus ();

    pipelined_barrel_shifter #(
        .WIDTH       (W),
        .SHIFT_WIDTH (SW),
        .PIPE_REGS   (PR),
        .TAG_WIDTH   (TW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {result, sticky}
    function automatic logic [16:0] ref_model(logic [15:0] op, logic [4:0] amt, logic [1:0] mode);
        int          a;
        logic [31:0] wide;
        logic [15:0] r;
        logic        s;
        a = int'(amt);
        if (mode == 2'b11) begin
            wide = {op, op} >> (a % 16);
            r    = wide[15:0];
            s    = 1'b0;
        end else if (a >= 16) begin
            r = (mode == 2'b10 && op[15]) ? 16'hFFFF : 16'h0000;
            s = |op;
        end else if (mode == 2'b00) begin
            wide = {16'h0000, op} << a;
            r    = wide[15:0];
            s    = |wide[31:16];
        end else begin
            wide = {op, 16'h0000} >> a;
            s    = |wide[15:0];
            r    = (mode == 2'b10) ? 16'($signed(op) >>> a) : wide[31:16];
        end
        return {r, s};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(beat_t b);
        bus.operand_i      = b.op;
        bus.shift_amount_i = b.amt;
        bus.mode_i         = shift_mode_e'(b.mode);
        bus.tag_i          = b.tag;
    endtask

    // Advance to the sampling point and run the scoreboard on the handshakes
    // that will complete at the next rising edge.
    task automatic tick_neg();
        logic [20:0] exp;
        @(negedge clk);
        if (rst_n) begin
            if (bus.in_valid_i && bus.in_ready_o) begin
                sb.push_back({ref_model(bus.operand_i, bus.shift_amount_i, bus.mode_i), bus.tag_i});
                mon_in++;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                mon_out++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_beat: got result 0x%0h tag %0d, expected no beat",
                             bus.result_o, bus.tag_o);
                end else begin
                    exp = sb.pop_front();
                    check("sb_beat", {11'd0, bus.result_o, bus.sticky_o, bus.tag_o}, {11'd0, exp});
                end
            end
        end
    endtask

    task automatic tick_pos();
        @(posedge clk);
        #1;
    endtask

    vec_t  vecs [14];
    beat_t bp   [4];

    initial begin
        int          n_acc;
        int          n_out;
        int          first_out;
        int          last_out;
        int          lat;
        int          seen;
        int          cyc;
        bit          got;
        bit          acc_last;
        logic [16:0] e0;
        beat_t       rb;

        checks  = 0;
        errors  = 0;
        mon_in  = 0;
        mon_out = 0;

        vecs[0]  = '{16'hF00F, 5'd4,  2'b01, 4'd3,  16'h0F00, 1'b1};
        vecs[1]  = '{16'h8000, 5'd20, 2'b10, 4'd1,  16'hFFFF, 1'b1};
        vecs[2]  = '{16'h4000, 5'd31, 2'b10, 4'd2,  16'h0000, 1'b1};
        vecs[3]  = '{16'h1234, 5'd20, 2'b11, 4'd4,  16'h4123, 1'b0};
        vecs[4]  = '{16'h00FF, 5'd12, 2'b00, 4'd5,  16'hF000, 1'b1};
        vecs[5]  = '{16'h0001, 5'd0,  2'b00, 4'd6,  16'h0001, 1'b0};
        vecs[6]  = '{16'h8001, 5'd1,  2'b10, 4'd7,  16'hC000, 1'b1};
        vecs[7]  = '{16'h8001, 5'd1,  2'b11, 4'd8,  16'hC000, 1'b0};
        vecs[8]  = '{16'h8000, 5'd15, 2'b01, 4'd9,  16'h0001, 1'b0};
        vecs[9]  = '{16'h8000, 5'd16, 2'b00, 4'd10, 16'h0000, 1'b1};
        vecs[10] = '{16'h0000, 5'd31, 2'b01, 4'd11, 16'h0000, 1'b0};
        vecs[11] = '{16'hF0F0, 5'd0,  2'b10, 4'd12, 16'hF0F0, 1'b0};
        vecs[12] = '{16'h00FF, 5'd31, 2'b11, 4'd13, 16'h01FE, 1'b0};
        vecs[13] = '{16'h1234, 5'd4,  2'b00, 4'd14, 16'h2340, 1'b1};

        bp[0] = '{16'hA5A5, 5'd3,  2'b01, 4'd1};
        bp[1] = '{16'h8421, 5'd5,  2'b10, 4'd2};
        bp[2] = '{16'h0F0F, 5'd9,  2'b00, 4'd3};
        bp[3] = '{16'hC3C3, 5'd22, 2'b11, 4'd4};

        // ---------------- reset state ----------------
        rst_n              = 1'b0;
        bus.in_valid_i     = 1'b0;
        bus.out_ready_i    = 1'b1;
        bus.operand_i      = '0;
        bus.shift_amount_i = '0;
        bus.mode_i         = SHIFT_LSL;
        bus.tag_i          = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("reset_in_ready",  32'(bus.in_ready_o),  32'd1);
        check("reset_result",    32'(bus.result_o),    32'd0);
        check("reset_sticky",    32'(bus.sticky_o),    32'd0);
        check("reset_tag",       32'(bus.tag_o),       32'd0);
        #2 rst_n = 1'b1;
        tick_pos();

        // ---------------- table-driven single beats ----------------
        for (int i = 0; i < 14; i++) begin
            drive('{vecs[i].op, vecs[i].amt, vecs[i].mode, vecs[i].tag});
            bus.in_valid_i  = 1'b1;
            bus.out_ready_i = 1'b1;
            tick_neg();
            check("vec_in_ready", 32'(bus.in_ready_o), 32'd1);
            tick_pos();
            bus.in_valid_i = 1'b0;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 10) begin
                tick_neg();
                lat++;
                if (bus.out_valid_o) begin
                    got = 1'b1;
                    check("vec_result", 32'(bus.result_o), 32'(vecs[i].res));
                    check("vec_sticky", 32'(bus.sticky_o), 32'(vecs[i].st));
                    check("vec_tag",    32'(bus.tag_o),    32'(vecs[i].tag));
                end
                tick_pos();
            end
            check("vec_latency", 32'(lat), 32'd2);
        end

        // ---------------- backpressure and stall stability ----------------
        n_acc     = 0;
        n_out     = 0;
        first_out = -1;
        last_out  = -1;
        e0        = ref_model(bp[0].op, bp[0].amt, bp[0].mode);
        for (int c = 0; c < 20; c++) begin
            bus.out_ready_i = (c >= 5);
            bus.in_valid_i  = (n_acc < 4);
            if (n_acc < 4) drive(bp[n_acc]);
            tick_neg();
            if (c >= 2 && c <= 4) begin
                check("bp_in_ready_low", 32'(bus.in_ready_o), 32'd0);
                check("bp_stall_valid",  32'(bus.out_valid_o), 32'd1);
                check("bp_stall_result", 32'(bus.result_o), 32'(e0[16:1]));
                check("bp_stall_sticky", 32'(bus.sticky_o), 32'(e0[0]));
                check("bp_stall_tag",    32'(bus.tag_o),    32'(bp[0].tag));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (n_out < 4) check("bp_order_tag", 32'(bus.tag_o), 32'(bp[n_out].tag));
                if (first_out < 0) first_out = c;
                last_out = c;
                n_out++;
            end
            if (bus.in_valid_i && bus.in_ready_o) n_acc++;
            tick_pos();
        end
        bus.in_valid_i = 1'b0;
        check("bp_beats_out",  32'(n_out), 32'd4);
        check("bp_first_out",  32'(first_out), 32'd5);
        check("bp_back_to_back", 32'(last_out - first_out), 32'd3);

        // ---------------- reset mid-flight ----------------
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid_i = 1'b1;
            drive(bp[i]);
            tick_neg();
            tick_pos();
        end
        bus.in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_mid_in_ready",  32'(bus.in_ready_o),  32'd1);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick_neg();
            if (bus.out_valid_o) seen++;
            tick_pos();
        end
        check("rst_no_ghost_beats", 32'(seen), 32'd0);
        check("rst_after_in_ready", 32'(bus.in_ready_o), 32'd1);

        // ---------------- randomized traffic ----------------
        mon_in   = 0;
        mon_out  = 0;
        n_acc    = 0;
        cyc      = 0;
        acc_last = 1'b0;
        while (n_acc < 10000 && cyc < 60000) begin
            if (!bus.in_valid_i || acc_last) begin
                bus.in_valid_i = ($urandom_range(3) != 0);
                rb.op   = 16'($urandom);
                rb.amt  = 5'($urandom_range(31));
                rb.mode = 2'($urandom_range(3));
                rb.tag  = 4'($urandom_range(15));
                drive(rb);
            end
            bus.out_ready_i = ($urandom_range(3) != 0);
            tick_neg();
            acc_last = bus.in_valid_i && bus.in_ready_o;
            if (acc_last) n_acc++;
            tick_pos();
            cyc++;
        end
        check("rand_accepted", 32'(n_acc), 32'd10000);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            tick_neg();
            tick_pos();
        end
        check("rand_drain_empty", 32'(sb.size()), 32'd0);
        check("rand_in_eq_out",   32'(mon_out), 32'(mon_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, multi-mode barrel shifter with configurable pipeline depth and a valid/ready handshake. It is the successor to the single-mode combinational shifter. It supports logical left, logical right, arithmetic right and rotate right. It also produces a sticky/overflow bit for rounding, and saturates shift amounts of WIDTH or more. It sits on the normalisation/alignment paths of the posit dot-product datapath, where these shifts currently close timing poorly as pure combinational logic.

Parameters:
WIDTH, 16, operand width in bits; power of two, >= 2 (elaboration assertion).
SHIFT_WIDTH, 5, shift-amount width; must satisfy 2**SHIFT_WIDTH >= WIDTH (elaboration assertion).
PIPE_REGS, 2, register stages; 0 = combinational path with handshake pass-through; max SHIFT_WIDTH.
TAG_WIDTH, 4, width of the user tag carried alongside the data.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  input beat valid
in_ready_o  output  1  block can accept an input beat
operand_i  input  WIDTH  data to shift
shift_amount_i  input  SHIFT_WIDTH  unsigned shift amount
mode_i  input  2  shift mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR
tag_i  input  TAG_WIDTH  user tag, passed through unchanged
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts the result
result_o  output  WIDTH  shifted result
sticky_o  output  1  LSR/ASR: OR of discarded bits; LSL: OR of bits shifted out of the MSB (overflow); ROR: 0
tag_o  output  TAG_WIDTH  tag of the current result

Behaviour:
- Reset: all stage valid bits are cleared asynchronously, so out_valid_o = 0. result_o, sticky_o and tag_o reset to 0. in_ready_o = 1 out of reset.
- Reset asserted mid-operation: all in-flight beats are discarded and none are emitted after release.
- Shift levels: SHIFT_WIDTH levels, level k shifts by 2**k when amount bit k is set, MSB level first.
- Level distribution across pipeline stages: levels are split over PIPE_REGS register boundaries as evenly as possible. Earlier stages take the extra level. A register follows each group.
- Mode, tag, remaining amount bits and the partial sticky are registered with the data at each boundary.
- LSL/LSR: zero fill. ASR: fill with operand MSB.
- ROR: the effective amount is shift_amount_i mod WIDTH, so amount bits >= log2(WIDTH) are ignored.
- Saturation: for LSL/LSR/ASR with amount >= WIDTH, the result is 0 (LSL/LSR) or all-ones/all-zeros per the sign (ASR). sticky_o = OR of all operand bits.
- Amount 0: result = operand, sticky_o = 0, for every mode.
- Sticky accumulation: sticky is accumulated per level as the OR of the bits removed at that level, then ORed into the carried sticky bit.
- Latency: PIPE_REGS cycles from accepted input to out_valid_o with no backpressure.
- Throughput: 1 beat/cycle.
- Handshake: a beat transfers when valid && ready on the same edge. Once out_valid_o is high, result_o, sticky_o and tag_o hold stable until out_ready_i is high.
- Elastic pipeline: stage n loads when it is empty or when stage n+1 loads/drains in the same cycle.
- in_ready_o = first stage empty, or first stage advancing this cycle. No combinational path from in_valid_i to in_ready_o.
- The out_ready_i to in_ready_o combinational chain is permitted.
- Capacity: PIPE_REGS beats in flight. Ordering is strictly FIFO.
- PIPE_REGS = 0: in_ready_o = out_ready_i, out_valid_o = in_valid_i, and results are combinational.
- Simultaneous drain and load in a full pipeline: both occur and no bubble is inserted.
- mode_i and tag_i are sampled only with the accepted beat.

Decomposition:
- Package pdpu_shift_pkg holds:
  - typedef enum logic [1:0] shift_mode_e {SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR};
  - the stage-payload struct typedef (data, remaining amount, mode, sticky, tag), parametrised by localparams in the module;
  - a constant function computing levels per stage.
- One sub-module is natural: shift_level. It is combinational and performs one 2**k shift level for all modes, with sticky extraction.
- The top instantiates SHIFT_WIDTH levels and PIPE_REGS payload registers with the valid/ready control.

Test Plan:
All scenarios use WIDTH=16, SHIFT_WIDTH=5, PIPE_REGS=2, out_ready_i=1 unless stated.
- LSR: 0xF00F, amount 4, tag 3 -> result 0x0F00, sticky 1, tag 3, out_valid_o exactly 2 cycles after accept.
- ASR saturation: 0x8000, amount 20 -> 0xFFFF, sticky 1. ASR 0x4000, amount 31 -> 0x0000, sticky 1.
- ROR wrap: 0x1234, amount 20 -> 0x4123, sticky 0. LSL 0x00FF, amount 12 -> 0xF000, sticky 1. LSL 0x0001, amount 0 -> 0x0001, sticky 0.
- Backpressure and stall stability: 4 back-to-back beats, out_ready_i low for 5 cycles:
  - in_ready_o drops after 2 beats are held;
  - result_o, sticky_o and tag_o stay stable while stalled;
  - on release, all 4 beats emerge in order, 1 per cycle.
- Reset mid-flight: rst_ni pulsed low asynchronously with 2 valid beats in flight -> out_valid_o = 0 immediately, no beat emitted after release, in_ready_o = 1.
- Random: 10k random operand/amount/mode/tag beats with random in_valid_i/out_ready_i, checked against a scoreboard model; no loss, no duplication, order preserved.
